// File: rtl/sha256_share_arbiter_if.sv
// Handshake bundle between two message sources, the arbiter and the shared SHA-256 core.
// The master side is the requester/hash-core environment; the slave side is the arbiter.
interface sha256_share_arbiter_if;
    logic [1:0] req;
    logic [7:0] s0_data;
    logic [7:0] s1_data;
    logic       s0_valid;
    logic       s1_valid;
    logic       s0_last;
    logic       s1_last;
    logic       s0_ready;
    logic       s1_ready;
    logic [1:0] gnt;
    logic [7:0] sha_data;
    logic       sha_valid;
    logic       sha_last;
    logic       sha_start;
    logic       sha_done;
    logic [1:0] done;
    logic [1:0] timeout;
    logic [7:0] byte_count;

    modport master (
        output req,
        output s0_data,
        output s1_data,
        output s0_valid,
        output s1_valid,
        output s0_last,
        output s1_last,
        output sha_done,
        input  s0_ready,
        input  s1_ready,
        input  gnt,
        input  sha_data,
        input  sha_valid,
        input  sha_last,
        input  sha_start,
        input  done,
        input  timeout,
        input  byte_count
    );

    modport slave (
        input  req,
        input  s0_data,
        input  s1_data,
        input  s0_valid,
        input  s1_valid,
        input  s0_last,
        input  s1_last,
        input  sha_done,
        output s0_ready,
        output s1_ready,
        output gnt,
        output sha_data,
        output sha_valid,
        output sha_last,
        output sha_start,
        output done,
        output timeout,
        output byte_count
    );
endinterface

// File: rtl/sha256_share_arbiter.sv
// Round-robin owner arbiter for one SHA-256 core shared by two byte-stream requesters.
// A job runs IDLE -> STREAM -> WAIT_DONE and ends on sha_done or on a wait timeout.
module sha256_share_arbiter #(
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic clk,
    input  logic rst,
    sha256_share_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STREAM    = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    // Counter only has to reach TIMEOUT-1; the abandon happens on that edge.
    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    state_t      state;
    logic [1:0]  gnt_q;
    logic        last_owner;
    logic [CW-1:0] wait_cnt;
    logic [7:0]  sha_data_q;
    logic        sha_valid_q;
    logic        sha_last_q;
    logic        sha_start_q;
    logic [1:0]  done_q;
    logic [1:0]  timeout_q;
    logic [7:0]  byte_count_q;

    logic        s0_ready_d;
    logic        s1_ready_d;
    logic        xfer0;
    logic        xfer1;
    logic        xfer;
    logic [7:0]  beat_data;
    logic        beat_last;
    logic [1:0]  grant_nxt;

    assign s0_ready_d = (state == STREAM) & gnt_q[0];
    assign s1_ready_d = (state == STREAM) & gnt_q[1];

    assign xfer0     = bus.s0_valid & s0_ready_d;
    assign xfer1     = bus.s1_valid & s1_ready_d;
    assign xfer      = xfer0 | xfer1;
    assign beat_data = xfer1 ? bus.s1_data : bus.s0_data;
    assign beat_last = xfer1 ? bus.s1_last : bus.s0_last;

    // last_owner=1 means requester 1 went last, so requester 0 wins a tie.
    always_comb begin
        grant_nxt = 2'b00;
        unique case (1'b1)
            bus.req == 2'b01: grant_nxt = 2'b01;
            bus.req == 2'b10: grant_nxt = 2'b10;
            bus.req == 2'b11: grant_nxt = last_owner ? 2'b01 : 2'b10;
            default:          grant_nxt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            gnt_q        <= 2'b00;
            last_owner   <= 1'b1;
            wait_cnt     <= '0;
            sha_data_q   <= 8'h00;
            sha_valid_q  <= 1'b0;
            sha_last_q   <= 1'b0;
            sha_start_q  <= 1'b0;
            done_q       <= 2'b00;
            timeout_q    <= 2'b00;
            byte_count_q <= 8'h00;
        end else begin
            sha_valid_q <= 1'b0;
            sha_last_q  <= 1'b0;
            sha_start_q <= 1'b0;
            done_q      <= 2'b00;
            timeout_q   <= 2'b00;
            case (state)
                IDLE: begin
                    if (grant_nxt != 2'b00) begin
                        gnt_q        <= grant_nxt;
                        byte_count_q <= 8'h00;
                        state        <= STREAM;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        sha_data_q  <= beat_data;
                        sha_valid_q <= 1'b1;
                        if (byte_count_q != 8'hFF) begin
                            byte_count_q <= byte_count_q + 8'd1;
                        end
                        if (beat_last) begin
                            sha_last_q  <= 1'b1;
                            sha_start_q <= 1'b1;
                            wait_cnt    <= '0;
                            state       <= WAIT_DONE;
                        end
                    end
                end
                WAIT_DONE: begin
                    // A completion on the final wait cycle beats the abandon.
                    if (bus.sha_done) begin
                        done_q     <= gnt_q;
                        last_owner <= gnt_q[1];
                        gnt_q      <= 2'b00;
                        state      <= IDLE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout_q  <= gnt_q;
                        last_owner <= gnt_q[1];
                        gnt_q      <= 2'b00;
                        state      <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: begin
                    gnt_q <= 2'b00;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.s0_ready   = s0_ready_d;
    assign bus.s1_ready   = s1_ready_d;
    assign bus.gnt        = gnt_q;
    assign bus.sha_data   = sha_data_q;
    assign bus.sha_valid  = sha_valid_q;
    assign bus.sha_last   = sha_last_q;
    assign bus.sha_start  = sha_start_q;
    assign bus.done       = done_q;
    assign bus.timeout    = timeout_q;
    assign bus.byte_count = byte_count_q;

endmodule

// File: tb/tb_sha256_share_arbiter.sv
// Self-checking bench for sha256_share_arbiter: vector table, corner sequences
// and a randomized run against a job-level reference model.
module tb_sha256_share_arbiter;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sha256_share_arbiter_if bus ();

    sha256_share_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phase 0 idle, 1 streaming, 2 waiting on the core.
    int         m_phase;
    int         m_owner;
    int         m_last;
    int         m_cnt;
    int         m_wait;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_lastb;
    logic       m_start;
    logic [1:0] m_done;
    logic [1:0] m_to;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_last = 1; m_cnt = 0; m_wait = 0;
        m_data = 8'h00; m_valid = 0; m_lastb = 0; m_start = 0;
        m_done = 2'b00; m_to = 2'b00;
    endtask

    task automatic model_step();
        logic       v;
        logic [7:0] d;
        logic       l;
        m_valid = 0; m_lastb = 0; m_start = 0; m_done = 2'b00; m_to = 2'b00;
        if (m_phase == 0) begin
            if (bus.req == 2'b11) begin
                m_owner = 1 - m_last; m_phase = 1; m_cnt = 0;
            end else if (bus.req != 2'b00) begin
                m_owner = (bus.req == 2'b10) ? 1 : 0; m_phase = 1; m_cnt = 0;
            end
        end else if (m_phase == 1) begin
            v = (m_owner == 1) ? bus.s1_valid : bus.s0_valid;
            d = (m_owner == 1) ? bus.s1_data : bus.s0_data;
            l = (m_owner == 1) ? bus.s1_last : bus.s0_last;
            if (v) begin
                m_data = d; m_valid = 1;
                if (m_cnt < 255) m_cnt++;
                if (l) begin
                    m_lastb = 1; m_start = 1; m_phase = 2; m_wait = 0;
                end
            end
        end else begin
            m_wait++;
            if (bus.sha_done) begin
                m_done[m_owner] = 1'b1; m_last = m_owner; m_phase = 0;
            end else if (m_wait == TO) begin
                m_to[m_owner] = 1'b1; m_last = m_owner; m_phase = 0;
            end
        end
    endtask

    task automatic check_all();
        logic [1:0] eg;
        eg = (m_phase != 0) ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
        chk("gnt", bus.gnt, eg);
        chk("sha_data", bus.sha_data, m_data);
        chk("sha_valid", bus.sha_valid, m_valid);
        chk("sha_last", bus.sha_last, m_lastb);
        chk("sha_start", bus.sha_start, m_start);
        chk("done", bus.done, m_done);
        chk("timeout", bus.timeout, m_to);
        chk("byte_count", bus.byte_count, m_cnt);
        chk("s0_ready", bus.s0_ready, (m_phase == 1 && m_owner == 0));
        chk("s1_ready", bus.s1_ready, (m_phase == 1 && m_owner == 1));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic clear_inputs();
        bus.req = 2'b00;
        bus.s0_data = 8'h00; bus.s1_data = 8'h00;
        bus.s0_valid = 0; bus.s1_valid = 0;
        bus.s0_last = 0; bus.s1_last = 0;
        bus.sha_done = 0;
    endtask

    typedef struct {
        logic [1:0] req;
        logic       s0v;
        logic [7:0] s0d;
        logic       s0l;
        logic       sdone;
        logic [1:0] e_gnt;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_last;
        logic       e_start;
        logic [1:0] e_done;
        logic [7:0] e_bc;
    } vec_t;

    vec_t tbl [15];

    initial begin
        int hit;
        int saw_done;
        int s1_leak;

        // Single job "abc": sha_done ten cycles after the last beat.
        tbl[0] = '{2'b01, 1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 1'b0, 8'hBB, 1'b0, 1'b0, 2'b00, 8'd0};
        tbl[1] = '{2'b00, 1'b1, 8'h61, 1'b0, 1'b0, 2'b01, 1'b1, 8'h61, 1'b0, 1'b0, 2'b00, 8'd1};
        tbl[2] = '{2'b00, 1'b1, 8'h62, 1'b0, 1'b0, 2'b01, 1'b1, 8'h62, 1'b0, 1'b0, 2'b00, 8'd2};
        tbl[3] = '{2'b00, 1'b1, 8'h63, 1'b1, 1'b0, 2'b01, 1'b1, 8'h63, 1'b1, 1'b1, 2'b00, 8'd3};
        for (int r = 4; r <= 12; r++) begin
            tbl[r] = '{2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 1'b0, 8'h63, 1'b0, 1'b0, 2'b00, 8'd3};
        end
        tbl[13] = '{2'b00, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 1'b0, 8'h63, 1'b0, 1'b0, 2'b01, 8'd3};
        tbl[14] = '{2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 8'h63, 1'b0, 1'b0, 2'b00, 8'd3};

        rst = 1'b1;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // Tie held over two jobs.
        bus.req = 2'b11;
        tick();
        chk("tie_first", bus.gnt, 2'b01);
        bus.s0_valid = 1; bus.s0_last = 1; bus.s0_data = 8'hAA;
        tick();
        bus.s0_valid = 0; bus.s0_last = 0; bus.sha_done = 1;
        tick();
        chk("tie_gap_gnt", bus.gnt, 2'b00);
        chk("tie_done0", bus.done, 2'b01);
        bus.sha_done = 0;
        tick();
        chk("tie_second", bus.gnt, 2'b10);
        bus.s1_valid = 1; bus.s1_last = 1; bus.s1_data = 8'hBB;
        tick();
        bus.s1_valid = 0; bus.s1_last = 0; bus.sha_done = 1;
        tick();
        chk("tie_done1", bus.done, 2'b10);
        clear_inputs();
        tick();

        for (int r = 0; r < 15; r++) begin
            bus.req = tbl[r].req;
            bus.s0_valid = tbl[r].s0v;
            bus.s0_data = tbl[r].s0d;
            bus.s0_last = tbl[r].s0l;
            bus.sha_done = tbl[r].sdone;
            tick();
            chk("tbl_gnt", bus.gnt, tbl[r].e_gnt);
            chk("tbl_valid", bus.sha_valid, tbl[r].e_valid);
            chk("tbl_data", bus.sha_data, tbl[r].e_data);
            chk("tbl_last", bus.sha_last, tbl[r].e_last);
            chk("tbl_start", bus.sha_start, tbl[r].e_start);
            chk("tbl_done", bus.done, tbl[r].e_done);
            chk("tbl_bc", bus.byte_count, tbl[r].e_bc);
        end
        clear_inputs();

        // Timeout on requester 1 with no completion.
        bus.req = 2'b10;
        tick();
        bus.req = 2'b00;
        bus.s1_valid = 1; bus.s1_last = 1; bus.s1_data = 8'h5A;
        tick();
        clear_inputs();
        hit = 0;
        saw_done = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (bus.done != 2'b00) saw_done = 1;
            if (bus.timeout != 2'b00) begin
                hit = k;
                break;
            end
        end
        chk("timeout_cycle", hit, TO);
        chk("timeout_owner", bus.timeout, 2'b10);
        chk("timeout_no_done", saw_done, 0);
        tick();
        chk("timeout_single", bus.timeout, 2'b00);

        // Completion on the same cycle as the timeout limit.
        bus.req = 2'b01;
        tick();
        bus.req = 2'b00;
        bus.s0_valid = 1; bus.s0_last = 1; bus.s0_data = 8'h77;
        tick();
        clear_inputs();
        repeat (TO - 1) tick();
        bus.sha_done = 1;
        tick();
        chk("collide_done", bus.done, 2'b01);
        chk("collide_timeout", bus.timeout, 2'b00);
        clear_inputs();
        tick();

        // Backpressure on s0 while s1 streams garbage.
        bus.req = 2'b01;
        tick();
        bus.req = 2'b00;
        s1_leak = 0;
        for (int i = 0; i < 8; i++) begin
            bus.s0_valid = (i % 2 == 0);
            bus.s0_data = 8'h20 + 8'(i);
            bus.s0_last = (i == 6);
            bus.s1_valid = 1; bus.s1_data = 8'hEE; bus.s1_last = 1;
            tick();
            chk("bp_s1_ready", bus.s1_ready, 1'b0);
            if (bus.sha_valid && bus.sha_data == 8'hEE) s1_leak++;
        end
        chk("bp_s1_leak", s1_leak, 0);
        chk("bp_bytes", bus.byte_count, 8'd4);
        clear_inputs();
        bus.sha_done = 1;
        tick();
        chk("bp_done", bus.done, 2'b01);
        clear_inputs();
        tick();

        // Reset in the middle of a stream.
        bus.req = 2'b01;
        tick();
        bus.req = 2'b00;
        bus.s0_valid = 1; bus.s0_data = 8'h31;
        tick();
        bus.s0_data = 8'h32;
        tick();
        chk("pre_rst_bc", bus.byte_count, 8'd2);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_gnt", bus.gnt, 2'b00);
        clear_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req = 2'b11;
        tick();
        chk("rst_tie", bus.gnt, 2'b01);
        bus.req = 2'b00;
        bus.s0_valid = 1; bus.s0_last = 1; bus.s0_data = 8'h44;
        tick();
        clear_inputs();
        bus.sha_done = 1;
        tick();
        clear_inputs();
        tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            bus.req = 2'($urandom_range(0, 3));
            bus.s0_valid = ($urandom_range(0, 2) != 0);
            bus.s1_valid = ($urandom_range(0, 2) != 0);
            bus.s0_data = 8'($urandom);
            bus.s1_data = 8'($urandom);
            bus.s0_last = ($urandom_range(0, 4) == 0);
            bus.s1_last = ($urandom_range(0, 4) == 0);
            bus.sha_done = ($urandom_range(0, 11) == 0);
            tick();
        end
        clear_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
